// File: rtl/lfsr_dds_modulator.sv
// ============================================================================
// Module   : lfsr_dds_modulator
// Purpose  : Single-clock DDS triangle-carrier generator with LFSR-keyed
//            modulation (none / ASK / FSK / BPSK). Samples are N-bit offset
//            binary (mid-scale = 2**(N-1)) and are always registered.
// Options  : FSK_EN - when defined, mod_sel=2'b10 selects tuning_word1 as the
//            phase increment while lfsr_out[0]=1. When undefined,
//            tuning_word1 is ignored and mod_sel=2'b10 is unmodulated.
// Ports    : clk          - fast clock, all state on posedge
//            reset        - asynchronous active-high reset
//            lfsr_tick    - one-cycle pulse, advances the LFSR one step
//            tuning_word0 - phase increment (carrier / FSK mark=0)
//            tuning_word1 - phase increment for FSK when lfsr_out[0]=1
//            mod_sel      - 00 none, 01 ASK, 10 FSK, 11 BPSK
//            sample_out   - modulated sample (registered)
//            sample_valid - high once the pipeline has filled after reset
//            carrier_out  - unmodulated triangle, aligned to sample_out
//            lfsr_out     - current LFSR state
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_dds_modulator #(
  parameter int N                      = 12,
  parameter int ACC_W                  = 32,
  parameter int LFSR_W                 = 5,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 5'b00001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lfsr_tick,
  input  logic [ACC_W-1:0]  tuning_word0,
  input  logic [ACC_W-1:0]  tuning_word1,
  input  logic [1:0]        mod_sel,
  output logic [N-1:0]      sample_out,
  output logic              sample_valid,
  output logic [N-1:0]      carrier_out,
  output logic [LFSR_W-1:0] lfsr_out
);

  localparam logic [N-1:0] c_MID = {1'b1, {(N-1){1'b0}}};

  localparam logic [1:0] c_MOD_NONE = 2'b00;
  localparam logic [1:0] c_MOD_ASK  = 2'b01;
  localparam logic [1:0] c_MOD_FSK  = 2'b10;
  localparam logic [1:0] c_MOD_BPSK = 2'b11;

  logic [ACC_W-1:0]  r_acc;
  logic [N-1:0]      r_tri;
  logic [1:0]        r_fill;
  logic [LFSR_W-1:0] r_lfsr;

  logic [ACC_W-1:0]  w_tw;
  logic [N-1:0]      w_phase;
  logic [N-1:0]      w_sample;
  logic [LFSR_W-1:0] w_lfsr_next;

  // Phase increment selection
`ifdef FSK_EN
  assign w_tw = ((mod_sel == c_MOD_FSK) && r_lfsr[0]) ? tuning_word1 : tuning_word0;
`else
  assign w_tw = tuning_word0;
  wire w_unused_tw1 = ^tuning_word1;
`endif

  // Bits just below the half-period MSB; folding on the MSB gives a triangle
  assign w_phase = r_acc[ACC_W-2 -: N];

  generate
    if (ACC_W > N + 1) begin : g_unused_acc_lsb
      wire w_unused_acc_lsb = ^r_acc[ACC_W-N-2:0];
    end
  endgenerate

  // Fibonacci LFSR x^5+x^3+1. An all-zero state is a lock-up, so it is
  // reloaded with the seed on the next edge even without a tick.
  always_comb begin
    w_lfsr_next = r_lfsr;
    if (r_lfsr == '0) begin
      w_lfsr_next = LFSR_SEED;
    end else if (lfsr_tick) begin
      w_lfsr_next = {r_lfsr[LFSR_W-2:0], r_lfsr[4] ^ r_lfsr[2]};
    end
  end

  // Modulation applied to the registered triangle
  always_comb begin
    w_sample = r_tri;
    case (mod_sel)
      c_MOD_NONE: w_sample = r_tri;
      c_MOD_ASK:  w_sample = r_lfsr[0] ? r_tri : c_MID;
      c_MOD_FSK:  w_sample = r_tri;
      c_MOD_BPSK: w_sample = r_lfsr[0] ? r_tri : ~r_tri;
      default:    w_sample = r_tri;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_tri       <= '0;
      sample_out  <= c_MID;
      carrier_out <= c_MID;
      r_fill      <= 2'd0;
      r_lfsr      <= LFSR_SEED;
    end else begin
      r_acc       <= r_acc + w_tw;
      r_tri       <= r_acc[ACC_W-1] ? ~w_phase : w_phase;
      carrier_out <= r_tri;
      sample_out  <= w_sample;
      // Saturating fill counter: valid once two edges have passed
      if (r_fill != 2'd2) begin
        r_fill <= r_fill + 2'd1;
      end
      r_lfsr      <= w_lfsr_next;
    end
  end

  assign sample_valid = r_fill[1];
  assign lfsr_out     = r_lfsr;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_dds_modulator.sv
// ============================================================================
// Module   : tb_lfsr_dds_modulator
// Purpose  : Directed self-checking bench for lfsr_dds_modulator (N=12,
//            ACC_W=32, LFSR_W=5). Expected values are hand-derived.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfsr_dds_modulator;

  logic        clk;
  logic        reset;
  logic        lfsr_tick;
  logic [31:0] tuning_word0;
  logic [31:0] tuning_word1;
  logic [1:0]  mod_sel;
  logic [11:0] sample_out;
  logic        sample_valid;
  logic [11:0] carrier_out;
  logic [4:0]  lfsr_out;

  int n_checks = 0;
  int n_pass   = 0;

  lfsr_dds_modulator dut (
    .clk          (clk),
    .reset        (reset),
    .lfsr_tick    (lfsr_tick),
    .tuning_word0 (tuning_word0),
    .tuning_word1 (tuning_word1),
    .mod_sel      (mod_sel),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .carrier_out  (carrier_out),
    .lfsr_out     (lfsr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
    n_checks++;
    if (obs === exp_val) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_val);
    end
  endtask

  // Advance n rising edges and settle just after the last one
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle tick pulse; returns just after the edge that consumes it
  task automatic tick();
    @(negedge clk);
    lfsr_tick = 1'b1;
    @(posedge clk);
    #1;
    lfsr_tick = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [11:0] prev;
  int          step_fsk;

  initial begin
    reset        = 1'b1;
    lfsr_tick    = 1'b0;
    tuning_word0 = 32'h0010_0000;
    tuning_word1 = 32'h0020_0000;
    mod_sel      = 2'b00;
    #1;

    // ---- Reset state ----
    check("rst_sample",  sample_out,   12'h800);
    check("rst_carrier", carrier_out,  12'h800);
    check("rst_valid",   sample_valid, 1'b0);
    check("rst_lfsr",    lfsr_out,     5'b00001);

    // ---- Ramp, tw0 = 2^20 -> triangle step 2; sample(n) = 2*(n-2) ----
    release_reset();
    edges(1);
    check("ramp_e1_valid",  sample_valid, 1'b0);
    check("ramp_e1_sample", sample_out,   12'd0);
    edges(1);
    check("ramp_e2_valid",  sample_valid, 1'b1);
    check("ramp_e2_sample", sample_out,   12'd0);
    edges(1);
    check("ramp_e3_sample", sample_out,   12'd2);
    edges(1);
    check("ramp_e4_sample", sample_out,   12'd4);
    edges(2046);   // edge 2050: acc at 2^31 folds to the peak
    check("ramp_peak_sample",  sample_out,  12'd4095);
    check("ramp_peak_carrier", carrier_out, 12'd4095);
    edges(1);      // edge 2051: descending
    check("ramp_desc_sample", sample_out, 12'd4093);
    edges(2047);   // edge 4098: acc wrapped to 0
    check("ramp_wrap_sample", sample_out, 12'd0);
    edges(1);
    check("ramp_wrap_next", sample_out, 12'd2);

    // ---- LFSR sequence, period 31 ----
    tick(); check("lfsr_t1", lfsr_out, 5'b00010);
    tick(); check("lfsr_t2", lfsr_out, 5'b00100);
    tick(); check("lfsr_t3", lfsr_out, 5'b01001);
    tick(); check("lfsr_t4", lfsr_out, 5'b10010);
    tick(); check("lfsr_t5", lfsr_out, 5'b00101);
    for (int i = 6; i <= 30; i++) begin
      tick();
      check("lfsr_not_seed_early", (lfsr_out == 5'b00001), 1'b0);
    end
    tick();
    check("lfsr_t31_seed", lfsr_out, 5'b00001);

    // ---- ASK ----
    mod_sel = 2'b01;
    tick();                         // lfsr 00010, bit0=0
    edges(1);
    check("ask_off_1", sample_out, 12'h800);
    edges(1);
    check("ask_off_2", sample_out, 12'h800);
    tick();                         // 00100
    tick();                         // 01001, edge still used old bit0=0
    check("ask_lfsr", lfsr_out, 5'b01001);
    check("ask_edge_old", sample_out, 12'h800);
    edges(1);
    check("ask_on_1", sample_out, carrier_out);
    edges(3);
    check("ask_on_2", sample_out, carrier_out);

    // ---- BPSK ----
    mod_sel = 2'b11;
    tick();                         // 10010, bit0=0
    for (int i = 0; i < 4; i++) begin
      edges(1);
      check("bpsk_inv", sample_out, 12'hFFF - carrier_out);
    end
    tick();                         // 00101, bit0=1
    edges(1);
    check("bpsk_pass", sample_out, carrier_out);

    // ---- FSK: reset so the ramp starts at 0 and stays on the up-slope ----
    @(negedge clk);
    reset   = 1'b1;
    mod_sel = 2'b10;
    #1;
    release_reset();
`ifdef FSK_EN
    step_fsk = 4;                   // lfsr[0]=1 after reset -> tw1=2^21
`else
    step_fsk = 2;
`endif
    edges(5);
    for (int i = 0; i < 3; i++) begin
      prev = carrier_out;
      edges(1);
      check("fsk_mark1_step", carrier_out - prev, step_fsk);
      check("fsk_mark1_eq",   sample_out, carrier_out);
    end
    tick();                         // 00010, bit0=0 -> tw0
    edges(4);
    for (int i = 0; i < 3; i++) begin
      prev = carrier_out;
      edges(1);
      check("fsk_mark0_step", carrier_out - prev, 2);
    end

    // ---- Reset mid-ramp, simultaneous with tick ----
    tick();                         // 00100
    @(negedge clk);
    reset     = 1'b1;
    lfsr_tick = 1'b1;
    #1;
    check("mid_rst_sample",  sample_out,   12'h800);
    check("mid_rst_carrier", carrier_out,  12'h800);
    check("mid_rst_valid",   sample_valid, 1'b0);
    check("mid_rst_lfsr",    lfsr_out,     5'b00001);
    edges(1);
    check("mid_rst_tick_ignored", lfsr_out, 5'b00001);
    @(negedge clk);
    reset     = 1'b0;
    lfsr_tick = 1'b0;
    edges(1);
    check("refill_e1_valid",  sample_valid, 1'b0);
    check("refill_e1_sample", sample_out,   12'd0);
    edges(1);
    check("refill_e2_valid",  sample_valid, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
